fetch_sequencer: RTL and testbench

Sequences instruction fetch for the sequential RISC-V core. It owns the program counter and drives a request/response handshake to the instruction memory. It holds each returned instruction in a one-entry output buffer until decode accepts it. It handles branch redirects, including squashing an in-flight response, and latches a sticky fault on a misaligned redirect target.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch
//                sequencer (FSM state encoding, instruction size, reset PC).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch FSM states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    // Size of one instruction in bytes; sequential PC step
    localparam int INST_BYTES = 4;

    // Default PC loaded on reset
    localparam logic [63:0] DEFAULT_RESET_PC = 64'd0;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Owns the program counter, issues one-cycle requests to the
//                instruction memory, buffers the returned word until decode
//                accepts it, handles branch redirects (squashing a response
//                that is already in flight) and latches a sticky fault on a
//                misaligned redirect target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            Clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    fetch_state_e    state_q,       state_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic            valid_q,       valid_d;
    logic [31:0]     inst_q,        inst_d;
    logic [XLEN-1:0] inst_pc_q,     inst_pc_d;
    logic            fault_q,       fault_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic            squash_q,      squash_d;

    logic            redir_misaligned;

    // A target that is not word aligned can never be fetched
    assign redir_misaligned = (redirect_pc[1:0] != 2'b00);

    // Next-state, PC, buffer and counter update
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        squash_d      = squash_q;

        if ((state_q != ST_FAULT) && redirect_valid) begin
            // Redirect wins over every other event; the buffer is stale either way
            valid_d = 1'b0;
            if (redir_misaligned) begin
                state_d  = ST_FAULT;
                fault_d  = 1'b1;
                squash_d = 1'b0;
            end else begin
                pc_d = redirect_pc;
                case (state_q)
                    ST_REQ: begin
                        // The old request is already out; its response must be dropped
                        state_d  = ST_WAIT;
                        squash_d = 1'b1;
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            // The stale response is arriving right now; drop it here
                            state_d  = ST_REQ;
                            squash_d = 1'b0;
                        end else begin
                            squash_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_REQ;
                    end
                endcase
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = ST_REQ;
                        end else begin
                            inst_d    = imem_rdata;
                            inst_pc_d = pc_q;
                            valid_d   = 1'b1;
                            state_d   = ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_d          = inst_pc_q + XLEN'(INST_BYTES);
                        fetch_count_d = fetch_count_q + 32'd1;
                        valid_d       = 1'b0;
                        state_d       = ST_REQ;
                    end
                end
                default: begin
                    // FAULT: everything frozen until reset
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            inst_q        <= 32'd0;
            inst_pc_q     <= '0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
            squash_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
            squash_q      <= squash_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'd0;

    logic            Clk = 1'b0;
    logic            reset_n;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            fault;
    logic [31:0]     fetch_count;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .Clk            (Clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== 32'd0 || inst_pc !== 64'd0 || fault !== 1'b0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: req=%b addr=%h v=%b inst=%h pc=%h fault=%b cnt=%h required all zero",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, fault, fetch_count);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        // IDLE -> REQ
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin
            errors++;
            $display("FAIL basic_req: req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        // REQ -> WAIT, memory answers this cycle
        tick();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait: req=%b v=%b required 0 0", imem_req, inst_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0031_0093;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0031_0093 || inst_pc !== 64'd0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid: v=%b inst=%h pc=%h req=%b required 1 00310093 0 0",
                     inst_valid, inst, inst_pc, imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd4 || fetch_count !== 32'd1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_next: req=%b addr=%h cnt=%0d v=%b required 1 4 1 0",
                     imem_req, imem_addr, fetch_count, inst_valid);
        end
    endtask

    task automatic test_stall();
        tick();                         // WAIT for addr 4
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0041_0113;
        stall       = 1'b1;
        tick();                         // VALID
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0041_0113 || inst_pc !== 64'd4 ||
                imem_req !== 1'b0 || fetch_count !== 32'd1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b inst=%h pc=%h req=%b cnt=%0d required 1 00410113 4 0 1",
                         i, inst_valid, inst, inst_pc, imem_req, fetch_count);
            end
            tick();
        end
        stall = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'd8 || fetch_count !== 32'd2) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h cnt=%0d required 1 8 2",
                     imem_req, imem_addr, fetch_count);
        end
    endtask

    task automatic test_redirect_req();
        // Currently in REQ for addr 8
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        tick();                         // WAIT with squash pending
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h40 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_drop: req=%b addr=%h v=%b required 1 40 0",
                     imem_req, imem_addr, inst_valid);
        end
        tick();                         // WAIT for 0x40
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h1111_1111 || inst_pc !== 64'h40) begin
            errors++;
            $display("FAIL redir_req_fetch: v=%b inst=%h pc=%h required 1 11111111 40",
                     inst_valid, inst, inst_pc);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h44 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL redir_req_next: req=%b addr=%h cnt=%0d required 1 44 3",
                     imem_req, imem_addr, fetch_count);
        end
    endtask

    task automatic test_redirect_rvalid();
        tick();                         // WAIT for 0x44
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h2222_2222;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h80 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_rv_req: req=%b addr=%h v=%b required 1 80 0",
                     imem_req, imem_addr, inst_valid);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_3333;
        stall       = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h3333_3333 || inst_pc !== 64'h80) begin
            errors++;
            $display("FAIL redir_rv_accept: v=%b inst=%h pc=%h required 1 33333333 80",
                     inst_valid, inst, inst_pc);
        end
        // Redirect out of VALID while decode is stalled
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h100 || inst_valid !== 1'b0 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL redir_valid: req=%b addr=%h v=%b cnt=%0d required 1 100 0 3",
                     imem_req, imem_addr, inst_valid, fetch_count);
        end
    endtask

    task automatic test_fault();
        // In REQ for 0x100
        redirect_valid = 1'b1;
        redirect_pc    = 64'h42;
        tick();
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_set: fault=%b req=%b v=%b required 1 0 0", fault, imem_req, inst_valid);
        end
        for (int i = 0; i < 20; i++) begin
            redirect_valid = i[0];
            redirect_pc    = 64'h200 + 64'(i * 4);
            imem_rvalid    = i[1];
            imem_rdata     = 32'h5555_0000 + 32'(i);
            tick();
            checks++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 64'h100) begin
                errors++;
                $display("FAIL fault_hold[%0d]: fault=%b req=%b v=%b addr=%h required 1 0 0 100",
                         i, fault, imem_req, inst_valid, imem_addr);
            end
        end
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        reset_n        = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || imem_addr !== RESET_PC || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL fault_reset: fault=%b addr=%h cnt=%0d required 0 0 0", fault, imem_addr, fetch_count);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL fault_restart: req=%b addr=%h required 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_count_wrap();
        // In REQ for addr 0
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        stall       = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        #1;
        checks++;
        if (fetch_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL count_preload: cnt=%h required ffffffff", fetch_count);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (fetch_count !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 64'd4) begin
            errors++;
            $display("FAIL count_wrap: cnt=%h req=%b addr=%h required 0 1 4", fetch_count, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_midwait();
        tick();                         // WAIT for addr 4, buffer still holds the old word
        reset_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== 32'd0 || inst_pc !== 64'd0 || fault !== 1'b0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_midwait: req=%b addr=%h v=%b inst=%h pc=%h fault=%b cnt=%h required all zero",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, fault, fetch_count);
        end
        // Stale response lands while the block sits in IDLE
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        reset_n     = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale: req=%b addr=%h v=%b required 1 0 0", imem_req, imem_addr, inst_valid);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0031_0093;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0031_0093 || inst_pc !== 64'd0) begin
            errors++;
            $display("FAIL reset_refetch: v=%b inst=%h pc=%h required 1 00310093 0", inst_valid, inst, inst_pc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_req();
        test_redirect_rvalid();
        test_fault();
        test_count_wrap();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
